// File: rtl/cpuc_mem_loader.sv
// cpuc_mem_loader: packs a byte stream little-endian into RAM words and writes them at incrementing addresses (checksum option: CPUC_LOADER_CSUM_EN)
module cpuc_mem_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  words_written,
    output logic [DATA_WIDTH-1:0] csum
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [CNT_WIDTH-1:0]  left;
    logic [IW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] word_buf;
    logic [DATA_WIDTH-1:0] packed_word;
    logic                  accept;
    logic                  last_byte;
    logic                  take_start;

    assign accept      = in_valid && state == COLLECT;
    assign last_byte   = byte_idx == IW'(BYTES - 1);
    assign take_start  = state == IDLE && start;
    assign packed_word = (word_buf & ~(DATA_WIDTH'(8'hFF) << {byte_idx, 3'b000}))
                       | (DATA_WIDTH'(in_data) << {byte_idx, 3'b000});

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake/status decode; the write strobe is masked during reset
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        ram_wren = 1'b0;
        case (state)
            IDLE:    state_nx = !start ? IDLE : (word_count == '0 ? DONE : COLLECT);
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                state_nx = abort ? IDLE : (accept && last_byte ? WRITE : COLLECT);
            end
            WRITE:   begin
                busy     = 1'b1;
                ram_wren = rst_n;
                state_nx = abort ? IDLE : (left == CNT_WIDTH'(1) ? DONE : COLLECT);
            end
            DONE:    begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch load parameters, assemble bytes, present the word for the write cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr      <= '0;
            left          <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            ram_address   <= '0;
            ram_data      <= '0;
            words_written <= '0;
        end else begin
            if (take_start) begin
                cur_addr      <= start_addr;
                left          <= word_count;
                byte_idx      <= '0;
                words_written <= '0;
            end
            if (accept && !abort) begin
                word_buf <= packed_word;
                byte_idx <= last_byte ? '0 : byte_idx + IW'(1);
                if (last_byte) begin
                    ram_address <= cur_addr;
                    ram_data    <= packed_word;
                end
            end
            if (state == WRITE) begin
                words_written <= words_written + CNT_WIDTH'(1);
                cur_addr      <= cur_addr + ADDR_WIDTH'(1);
                left          <= left - CNT_WIDTH'(1);
            end
        end
    end

`ifdef CPUC_LOADER_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;

    // Checksum: cleared on an accepted start, accumulates every written word
    always_ff @(posedge clk) begin
        if (!rst_n)              csum_q <= '0;
        else if (take_start)     csum_q <= '0;
        else if (state == WRITE) csum_q <= csum_q + ram_data;
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif
endmodule

// File: tb/tb_cpuc_mem_loader.sv
// tb_cpuc_mem_loader: directed loads checked against a word-level model of the expected RAM writes
module tb_cpuc_mem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] word_count = '0;
    logic [7:0]  in_data = '0;
    logic        in_ready, ram_wren, busy, done;
    logic [31:0] ram_address, ram_data, csum;
    logic [15:0] words_written;

`ifdef CPUC_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    int          n_pass = 0;
    int          n_tot = 0;
    logic [31:0] exp_addr [64];
    logic [31:0] exp_data [64];
    int          exp_n = 0;
    bit          exp_done = 1'b0;
    int          load_id = 0;
    int          m_seen = 0;
    int          m_rd = 0;
    int          m_dcnt = 0;
    logic [31:0] m_csum = '0;
    logic [31:0] mem [logic [31:0]];
    int          lat;

    always #5 clk = ~clk;

    cpuc_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .word_count(word_count), .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_address(ram_address), .ram_wren(ram_wren),
        .ram_data(ram_data), .busy(busy), .done(done), .words_written(words_written),
        .csum(csum)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [7:0] bval(input logic [7:0] base, input int i);
        return 8'(int'(base) + 17 * i);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hxxxxxxxx;
    endfunction

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_ram_wren"}, ram_wren, 0);
        check({tag, "_ram_address"}, ram_address, 0);
        check({tag, "_ram_data"}, ram_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_words_written"}, words_written, 0);
        check({tag, "_csum"}, csum, 0);
    endtask

    // mode 0: full load and wait for done; 1: abort after nb bytes; 2: hold reset after nb bytes
    task automatic do_load(input logic [31:0] a, input logic [15:0] cnt, input logic [7:0] base,
                           input bit tog, input int mode, input int nb, output int lt);
        int i;
        int guard;
        bit ph;
        @(posedge clk); #1;
        exp_n    = (mode == 0) ? int'(cnt) : nb / 4;
        exp_done = (mode == 0);
        if (mode == 0) nb = int'(cnt) * 4;
        for (int w = 0; w < exp_n; w++) begin
            exp_addr[w] = a + 32'(w);
            exp_data[w] = {bval(base, 4*w+3), bval(base, 4*w+2), bval(base, 4*w+1), bval(base, 4*w)};
        end
        load_id++;
        start = 1'b1; start_addr = a; word_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0; guard = 0; ph = 1'b1;
        while (i < nb && guard < 400) begin
            in_valid = tog ? ph : 1'b1;
            in_data  = bval(base, i);
            ph = !ph;
            guard++;
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("feed_bytes", i, nb);
        lt = 0;
        if (mode == 1) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end else if (mode == 2) begin
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end else begin
            do begin
                @(negedge clk);
                lt++;
            end while (!done && lt < 200);
            check("done_seen", done, 1);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every write must match the next expected word; done must close a complete load
    initial forever begin
        @(negedge clk);
        if (m_seen != load_id) begin
            m_seen = load_id; m_rd = 0; m_dcnt = 0; m_csum = '0;
        end
        if (rst_n && ram_wren) begin
            if (m_rd < exp_n) begin
                check("wr_addr", ram_address, exp_addr[m_rd]);
                check("wr_data", ram_data, exp_data[m_rd]);
            end else check("unexpected_wr", 1, 0);
            m_rd++;
            m_csum += ram_data;
            mem[ram_address] = ram_data;
        end
        if (rst_n && done) begin
            check("done_expected", exp_done && m_dcnt == 0, 1);
            check("done_writes", m_rd, exp_n);
            check("done_words_written", words_written, exp_n);
            check("done_csum", csum, CSUM_EN ? m_csum : 32'h0);
            m_dcnt++;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        mem.delete();
        do_load(32'h10, 16'd2, 8'h11, 1'b0, 0, 0, lat);
        check("lat_cont", lat, 2);
        check("mem10", mem_rd(32'h10), 32'h44332211);
        check("mem11", mem_rd(32'h11), 32'h88776655);
        check("ww_load1", words_written, 2);
        check("csum_load1", csum, CSUM_EN ? 32'hCCAA8866 : 32'h0);
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        do_load(32'h80, 16'd1, 8'h99, 1'b0, 2, 2, lat);
        check_zero("rst_mid");
        rst_n = 1'b1;
        mem.delete();
        do_load(32'h10, 16'd2, 8'h11, 1'b1, 0, 0, lat);
        check("tog_mem10", mem_rd(32'h10), 32'h44332211);
        check("tog_mem11", mem_rd(32'h11), 32'h88776655);
        check("tog_mem_count", mem.num(), 2);
        do_load(32'h20, 16'd0, 8'h11, 1'b0, 0, 0, lat);
        check("lat_zero", lat, 1);
        check("ww_zero", words_written, 0);
        check("zero_no_write", mem.num(), 2);
        mem.delete();
        do_load(32'hFFFFFFFF, 16'd2, 8'h01, 1'b0, 0, 0, lat);
        check("wrap_memFFFFFFFF", mem_rd(32'hFFFFFFFF), 32'h34231201);
        check("wrap_mem0", mem_rd(32'h0), 32'h78675645);
        mem.delete();
        do_load(32'h40, 16'd2, 8'h21, 1'b0, 1, 6, lat);
        repeat (10) @(negedge clk);
        check("ww_abort", words_written, 1);
        check("busy_abort", busy, 0);
        check("abort_mem40", mem_rd(32'h40), 32'h54433221);
        check("abort_no_mem41", mem.exists(32'h41), 0);
        do_load(32'h50, 16'd1, 8'h11, 1'b0, 0, 0, lat);
        check("restart_mem50", mem_rd(32'h50), 32'h44332211);
        check("restart_ww", words_written, 1);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
